// File: rtl/mfp_als_spi_master_if.sv
// Pin-level bundle between the PMOD ALS SPI master, the sensor pins and the
// peripheral logic that consumes the light value.
interface mfp_als_spi_master_if;
  logic       en;
  logic       cs;
  logic       sck;
  logic       sdo;
  logic [7:0] value;
  logic       valid;
  logic       busy;

  modport master (input en, sdo, output cs, sck, value, valid, busy);
  modport slave  (output en, sdo, input cs, sck, value, valid, busy);
endinterface

// File: rtl/mfp_als_spi_master.sv
// SPI master for the PMOD ALS light sensor: free-running sck, autonomous
// 16-bit frames separated by a cs-high gap, light value = frame bits 11:4.
module mfp_als_spi_master #(
  parameter int unsigned SCK_HALF    = 8,
  parameter int unsigned GAP_PERIODS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mfp_als_spi_master_if.master bus
);
  localparam int unsigned DIV_W = $clog2(SCK_HALF);
  localparam int unsigned GAP_W = $clog2(GAP_PERIODS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_PERIODS);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic {
    ST_GAP,
    ST_FRAME
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             sck_q;
  logic [3:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      shift_q;
  logic             cs_q;
  logic [7:0]       value_q;
  logic             valid_q;

  logic        div_last;
  logic        rise;
  logic [15:0] word_nxt;
  logic        unused_bits;

  // NOTE: combinational nets are plain continuous assigns, so no latch can form.
  assign div_last    = (div_cnt == DIV_LAST);
  assign rise        = div_last & ~sck_q;
  // sdo is sampled raw: the sensor holds it for a full sck half-period.
  assign word_nxt    = {shift_q[14:0], bus.sdo};
  assign unused_bits = ^{shift_q[15], word_nxt[15:12], word_nxt[3:0]};

  // NOTE: every register here is updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_GAP;
      div_cnt <= '0;
      sck_q   <= 1'b1;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (div_last) begin
        div_cnt <= '0;
        sck_q   <= ~sck_q;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end

      if (rise) begin
        case (state)
          ST_GAP: begin
            if (gap_cnt == GAP_FULL) begin
              if (bus.en) begin
                cs_q    <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_FRAME;
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_ONE;
            end
          end
          ST_FRAME: begin
            shift_q <= word_nxt;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              cs_q    <= 1'b1;
              value_q <= word_nxt[11:4];
              valid_q <= 1'b1;
              // The rise that raises cs already counts as the first gap period.
              gap_cnt <= GAP_ONE;
              state   <= ST_GAP;
            end
          end
        endcase
      end
    end
  end

  assign bus.cs    = cs_q;
  assign bus.sck   = sck_q;
  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.busy  = ~cs_q;
endmodule

// File: tb/tb_mfp_als_spi_master.sv
// Self-checking bench for mfp_als_spi_master: default and corner-parameter
// instances, each fed by a behavioural PMOD ALS sensor model.
`timescale 1ns/1ps
module tb_mfp_als_spi_master;
  localparam int SH     = 8;
  localparam int GP     = 4;
  localparam int SH_C   = 2;
  localparam int GP_C   = 1;
  localparam int PER    = 2 * SH;
  localparam int PER_C  = 2 * SH_C;

  logic clk;
  logic rst_n;
  int   edge_n;
  int   vectors;
  int   miscompares;

  mfp_als_spi_master_if bus ();
  mfp_als_spi_master_if bus_c ();

  mfp_als_spi_master #(.SCK_HALF(SH), .GAP_PERIODS(GP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mfp_als_spi_master #(.SCK_HALF(SH_C), .GAP_PERIODS(GP_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release: edge N is the Nth rising clk edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  // Sensor models: reload the word on sck falls while cs is high, shift out
  // MSB first on sck falls while cs is low.
  logic [15:0] word_q[$];
  logic [15:0] word_c_q[$];
  logic [15:0] stub_word;
  logic [15:0] stub_word_c;
  logic [15:0] sens_sr;
  logic [15:0] sens_sr_c;

  always @(negedge bus.sck) begin
    if (bus.cs) sens_sr = (word_q.size() != 0) ? word_q[0] : stub_word;
    else begin
      bus.sdo = sens_sr[15];
      sens_sr = {sens_sr[14:0], 1'b0};
    end
  end
  always @(negedge bus.cs) if (word_q.size() != 0) void'(word_q.pop_front());

  always @(negedge bus_c.sck) begin
    if (bus_c.cs) sens_sr_c = (word_c_q.size() != 0) ? word_c_q[0] : stub_word_c;
    else begin
      bus_c.sdo = sens_sr_c[15];
      sens_sr_c = {sens_sr_c[14:0], 1'b0};
    end
  end
  always @(negedge bus_c.cs) if (word_c_q.size() != 0) void'(word_c_q.pop_front());

  // Event log, sampled on the falling clk edge.
  int         cs_fall_q[$];
  int         cs_rise_q[$];
  int         rises_q[$];
  int         valid_q[$];
  logic [7:0] vval_q[$];
  int         valid_c_q[$];
  logic [7:0] vval_c_q[$];
  int         frame_rises;
  int         busy_bad;
  logic       prev_cs;
  logic       prev_sck;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!prev_sck && bus.sck && !prev_cs) frame_rises++;
      if (prev_cs && !bus.cs) begin
        cs_fall_q.push_back(edge_n);
        frame_rises = 0;
      end
      if (!prev_cs && bus.cs) begin
        cs_rise_q.push_back(edge_n);
        rises_q.push_back(frame_rises);
      end
      if (bus.valid) begin
        valid_q.push_back(edge_n);
        vval_q.push_back(bus.value);
      end
      if (bus.busy !== ~bus.cs) busy_bad++;
      if (bus_c.valid) begin
        valid_c_q.push_back(edge_n);
        vval_c_q.push_back(bus_c.value);
      end
    end
    prev_cs  = bus.cs;
    prev_sck = bus.sck;
  end

  task automatic clear_logs();
    cs_fall_q.delete();
    cs_rise_q.delete();
    rises_q.delete();
    valid_q.delete();
    vval_q.delete();
    valid_c_q.delete();
    vval_c_q.delete();
    busy_bad = 0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_sck;
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    vectors += 5;
    if (bus.cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b want 1", bus.cs); end
    if (bus.sck !== 1'b1) begin miscompares++; $display("FAIL reset_sck: got %b want 1", bus.sck); end
    if (bus.value !== 8'h00) begin miscompares++; $display("FAIL reset_value: got %h want 00", bus.value); end
    if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    clear_logs();
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      exp_sck = ((edge_n / SH) % 2) == 0;
      vectors += 2;
      if (bus.sck !== exp_sck) begin
        miscompares++;
        $display("FAIL idle_sck at edge %0d: got %b want %b", edge_n, bus.sck, exp_sck);
      end
      if (bus.cs !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_cs at edge %0d: got %b want 1", edge_n, bus.cs);
      end
    end
  endtask

  task automatic test_single_conversion();
    int t;
    stub_word = {4'($urandom), 8'hAB, 4'($urandom)};
    bus.en = 1'b1;
    apply_reset(3);
    t = 0;
    while (valid_q.size() == 0 && t < 500) begin @(negedge clk); t++; end
    vectors++;
    if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_width: got %b want 0", bus.valid); end
    vectors++;
    if (valid_q.size() != 1 || cs_fall_q.size() != 1 || cs_rise_q.size() != 1) begin
      miscompares++;
      $display("FAIL single_events: got valid=%0d fall=%0d rise=%0d want 1 each",
               valid_q.size(), cs_fall_q.size(), cs_rise_q.size());
    end else begin
      vectors += 5;
      if (cs_fall_q[0] != (GP + 1) * PER) begin
        miscompares++; $display("FAIL single_cs_fall: got %0d want %0d", cs_fall_q[0], (GP + 1) * PER);
      end
      if (rises_q[0] != 16) begin
        miscompares++; $display("FAIL single_sck_rises: got %0d want 16", rises_q[0]);
      end
      if (cs_rise_q[0] - cs_fall_q[0] != 16 * PER) begin
        miscompares++; $display("FAIL single_cs_low: got %0d want %0d", cs_rise_q[0] - cs_fall_q[0], 16 * PER);
      end
      if (valid_q[0] != cs_rise_q[0]) begin
        miscompares++; $display("FAIL single_valid_edge: got %0d want %0d", valid_q[0], cs_rise_q[0]);
      end
      if (vval_q[0] !== 8'hAB) begin
        miscompares++; $display("FAIL single_value: got %h want ab", vval_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[5];
    logic [15:0] w;
    int          t;
    words[0] = 16'h0000;
    words[1] = 16'hF5AF;
    words[2] = 16'h0FF0;
    words[3] = 16'($urandom);
    words[4] = 16'($urandom);
    word_q.delete();
    for (int i = 0; i < 5; i++) word_q.push_back(words[i]);
    stub_word = 16'h0000;
    bus.en = 1'b1;
    apply_reset(3);
    t = 0;
    while (valid_q.size() < 5 && t < 2000) begin @(negedge clk); t++; end
    vectors++;
    if (valid_q.size() < 5) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 5", valid_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        w = words[i];
        vectors += 3;
        if (vval_q[i] !== w[11:4]) begin
          miscompares++; $display("FAIL b2b_value[%0d]: got %h want %h", i, vval_q[i], w[11:4]);
        end
        if (valid_q[i] != (GP + 17) * PER + i * (16 + GP) * PER) begin
          miscompares++;
          $display("FAIL b2b_valid_edge[%0d]: got %0d want %0d", i, valid_q[i], (GP + 17) * PER + i * (16 + GP) * PER);
        end
        if (rises_q[i] != 16) begin
          miscompares++; $display("FAIL b2b_sck_rises[%0d]: got %0d want 16", i, rises_q[i]);
        end
      end
    end
    vectors++;
    if (busy_bad != 0) begin miscompares++; $display("FAIL b2b_busy_vs_cs: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_en_drop();
    logic [7:0] v;
    int         t;
    int         e0;
    int         exp_fall;
    v = 8'($urandom);
    word_q.delete();
    stub_word = {4'($urandom), v, 4'($urandom)};
    bus.en = 1'b1;
    apply_reset(3);
    t = 0;
    while (cs_fall_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    while (frame_rises < 8 && t < 400) begin @(negedge clk); t++; end
    bus.en = 1'b0;
    repeat (2300) @(negedge clk);
    vectors++;
    if (cs_fall_q.size() != 1 || valid_q.size() != 1 || cs_rise_q.size() != 1) begin
      miscompares++;
      $display("FAIL endrop_events: got fall=%0d valid=%0d rise=%0d want 1 each",
               cs_fall_q.size(), valid_q.size(), cs_rise_q.size());
    end else begin
      vectors += 2;
      if (vval_q[0] !== v) begin miscompares++; $display("FAIL endrop_value: got %h want %h", vval_q[0], v); end
      if (edge_n - cs_rise_q[0] < 2000) begin
        miscompares++; $display("FAIL endrop_cs_high: got %0d want >=2000", edge_n - cs_rise_q[0]);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
      e0 = edge_n;
      bus.en = 1'b1;
      exp_fall = (e0 / PER + 1) * PER;
      t = 0;
      while (valid_q.size() < 2 && t < 600) begin @(negedge clk); t++; end
      vectors++;
      if (cs_fall_q.size() != 2 || valid_q.size() != 2) begin
        miscompares++; $display("FAIL endrop_restart: got fall=%0d valid=%0d want 2", cs_fall_q.size(), valid_q.size());
      end else begin
        vectors += 3;
        if (cs_fall_q[1] != exp_fall) begin
          miscompares++; $display("FAIL endrop_restart_edge: got %0d want %0d", cs_fall_q[1], exp_fall);
        end
        if (cs_fall_q[1] - cs_rise_q[0] < GP * PER) begin
          miscompares++; $display("FAIL endrop_min_gap: got %0d want >=%0d", cs_fall_q[1] - cs_rise_q[0], GP * PER);
        end
        if (vval_q[1] !== v) begin miscompares++; $display("FAIL endrop_value2: got %h want %h", vval_q[1], v); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    int         t;
    v = 8'($urandom);
    word_q.delete();
    stub_word = {4'($urandom), v, 4'($urandom)};
    bus.en = 1'b1;
    apply_reset(3);
    t = 0;
    while (cs_fall_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    while (frame_rises < 8 && t < 400) begin @(negedge clk); t++; end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (bus.cs !== 1'b1) begin miscompares++; $display("FAIL areset_cs: got %b want 1", bus.cs); end
    if (bus.sck !== 1'b1) begin miscompares++; $display("FAIL areset_sck: got %b want 1", bus.sck); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
    if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b want 0", bus.valid); end
    if (bus.value !== 8'h00) begin miscompares++; $display("FAIL areset_value: got %h want 00", bus.value); end
    repeat (3) @(negedge clk);
    vectors++;
    if (valid_q.size() != 0) begin miscompares++; $display("FAIL areset_no_valid: got %0d pulses want 0", valid_q.size()); end
    clear_logs();
    rst_n = 1'b1;
    t = 0;
    while (valid_q.size() == 0 && t < 500) begin @(negedge clk); t++; end
    vectors++;
    if (valid_q.size() != 1) begin
      miscompares++; $display("FAIL areset_refill: got %0d pulses want 1", valid_q.size());
    end else begin
      vectors += 2;
      if (valid_q[0] != (GP + 17) * PER) begin
        miscompares++; $display("FAIL areset_valid_edge: got %0d want %0d", valid_q[0], (GP + 17) * PER);
      end
      if (vval_q[0] !== v) begin miscompares++; $display("FAIL areset_value2: got %h want %h", vval_q[0], v); end
    end
  endtask

  task automatic test_param_corner();
    logic [15:0] words[5];
    logic [15:0] w;
    int          t;
    words[0] = {4'($urandom), 8'hAB, 4'($urandom)};
    for (int i = 1; i < 5; i++) words[i] = 16'($urandom);
    word_c_q.delete();
    for (int i = 0; i < 5; i++) word_c_q.push_back(words[i]);
    stub_word_c = words[0];
    apply_reset(3);
    t = 0;
    while (valid_c_q.size() < 5 && t < 600) begin @(negedge clk); t++; end
    vectors++;
    if (valid_c_q.size() < 5) begin
      miscompares++; $display("FAIL corner_count: got %0d want 5", valid_c_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        w = words[i];
        vectors += 2;
        if (vval_c_q[i] !== w[11:4]) begin
          miscompares++; $display("FAIL corner_value[%0d]: got %h want %h", i, vval_c_q[i], w[11:4]);
        end
        if (valid_c_q[i] != (GP_C + 17) * PER_C + i * (16 + GP_C) * PER_C) begin
          miscompares++;
          $display("FAIL corner_valid_edge[%0d]: got %0d want %0d", i, valid_c_q[i],
                   (GP_C + 17) * PER_C + i * (16 + GP_C) * PER_C);
        end
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    vectors     = 0;
    miscompares = 0;
    frame_rises = 0;
    busy_bad    = 0;
    bus.en      = 1'b0;
    bus_c.en    = 1'b1;
    stub_word   = 16'h0000;
    stub_word_c = 16'h0000;
    test_reset();
    test_single_conversion();
    test_back_to_back();
    test_en_drop();
    test_async_reset();
    test_param_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
